// File: rtl/collision_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : collision_sweep_ctrl
// Description : Frame-level collision sweep scheduler. Reads every lattice
//               cell in ascending address order and streams its densities
//               into the collision unit. Writes each collided result back to
//               the address it came from, then pulses frame completion.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_sweep_ctrl #(
    parameter int GRID_W       = 64,
    parameter int GRID_H       = 48,
    parameter int READ_LATENCY = 2,
    parameter int MAX_INFLIGHT = 32,
    parameter int ADDR_W       = $clog2(GRID_W * GRID_H)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              error_out,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [71:0]       rd_data_in,
    output logic [71:0]       coll_data_out,
    output logic              coll_valid_out,
    input  logic [71:0]       coll_result_in,
    input  logic              coll_done_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [71:0]       wr_data_out
);

    localparam int                NUM_CELLS    = GRID_W * GRID_H;
    localparam int                CNT_W        = $clog2(MAX_INFLIGHT) + 1;
    localparam int                PTR_W        = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int                TAIL         = READ_LATENCY - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_CELLS - 1);
    localparam logic [CNT_W-1:0]  INFLIGHT_MAX = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                issue;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]    inflight;
    logic [TAIL:0]       vld_pipe;
    logic [ADDR_W-1:0]   addr_pipe [READ_LATENCY];
    logic [ADDR_W-1:0]   fifo_mem  [MAX_INFLIGHT];
    logic [PTR_W-1:0]    fifo_wr_ptr;
    logic [PTR_W-1:0]    fifo_rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic                push;
    logic                push_ok;
    logic                pop_ok;
    logic                pop_err;
    logic                overflow;

    // The address that leaves the latency pipe alongside its data is queued
    // until the collision unit hands back the matching (in-order) result.
    assign push     = vld_pipe[TAIL];
    assign pop_ok   = coll_done_in && (fifo_cnt != '0);
    assign pop_err  = coll_done_in && (fifo_cnt == '0);
    assign overflow = push && (fifo_cnt == INFLIGHT_MAX) && !pop_ok;
    assign push_ok  = push && !overflow;

    assign rd_en_out   = issue;
    assign rd_addr_out = rd_ptr;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, read issue throttled by the in-flight limit, done pulse
    always_comb begin
        state_nxt      = state;
        issue          = 1'b0;
        frame_done_out = 1'b0;
        case (state)
            IDLE:  if (start_in) state_nxt = ISSUE;
            ISSUE: begin
                if (inflight < INFLIGHT_MAX) begin
                    issue = 1'b1;
                    if (rd_ptr == LAST_ADDR) state_nxt = DRAIN;
                end
            end
            DRAIN: if (inflight == '0) state_nxt = DONE;
            DONE: begin
                frame_done_out = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Busy flag and read pointer
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_out <= 1'b0;
            rd_ptr   <= '0;
        end else begin
            if ((state == IDLE) && start_in) begin
                busy_out <= 1'b1;
                rd_ptr   <= '0;
            end else if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (state == DONE) busy_out <= 1'b0;
        end
    end

    // Cells read but not yet written back
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            inflight <= '0;
        end else begin
            case ({issue, wr_en_out})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Match BRAM latency: read valid and its address travel together
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) addr_pipe[i] <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            addr_pipe[0] <= rd_ptr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    // Forward returned densities to the collision unit; data holds when idle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            coll_valid_out <= 1'b0;
            coll_data_out  <= '0;
        end else begin
            coll_valid_out <= vld_pipe[TAIL];
            if (vld_pipe[TAIL]) coll_data_out <= rd_data_in;
        end
    end

    // Address FIFO storage (no reset needed, occupancy is tracked separately)
    always_ff @(posedge clk_in) begin
        if (push_ok) fifo_mem[fifo_wr_ptr] <= addr_pipe[TAIL];
    end

    // Address FIFO pointers and occupancy
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
        end else begin
            if (push_ok) fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            if (pop_ok)  fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Write-back one cycle after each result, tagged with the queued address
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
        end else begin
            wr_en_out <= pop_ok;
            if (pop_ok) begin
                wr_addr_out <= fifo_mem[fifo_rd_ptr];
                wr_data_out <= coll_result_in;
            end
        end
    end

    // Sticky error: orphan result or dropped address
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                    error_out <= 1'b0;
        else if (pop_err || overflow)  error_out <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_collision_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_sweep_ctrl
// Description : Self-checking bench for collision_sweep_ctrl. Three 4x4
//               instances (read latency 1/2/3, in-flight limit 32/4/32) share
//               start/reset and each has its own BRAM and 20-cycle collision
//               model. A per-instance sweep model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_sweep_ctrl;

    localparam int N    = 16;
    localparam int CLAT = 20;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic spur  = 1'b0;
    logic to_flag = 1'b0;
    bit   to_seen = 1'b0;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    // Sweep model state per instance
    bit active  [3];
    int issued  [3];
    int written [3];
    int cv_n    [3];
    int done_n  [3];
    int wr_idx  [3];
    int dwait   [3];
    bit wr_pend [3];
    bit err_m   [3];
    int itime   [3][N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Lattice contents: byte d of cell a
    function automatic logic [71:0] bram_word(input int a);
        logic [71:0] w;
        for (int d = 0; d < 9; d++) w[d*8 +: 8] = 8'((a * 16 + d) % 256) ^ 8'hA5;
        return w;
    endfunction

    // Collision model: +1 per density byte
    function automatic logic [71:0] plus1(input logic [71:0] w);
        logic [71:0] r;
        for (int d = 0; d < 9; d++) r[d*8 +: 8] = w[d*8 +: 8] + 8'd1;
        return r;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_inst
        localparam int RL = k + 1;
        localparam int MI = (k == 1) ? 4 : 32;
        logic        busy, fdone, err, rd_en, cv, done_in, wr_en;
        logic [3:0]  rd_addr, wr_addr;
        logic [71:0] rd_data, cdata, cres, wr_data;
        logic [3:0]  ap  [RL];
        logic        av  [RL];
        logic        cvp [CLAT];
        logic [71:0] cdp [CLAT];

        collision_sweep_ctrl #(
            .GRID_W(4), .GRID_H(4), .READ_LATENCY(RL), .MAX_INFLIGHT(MI)
        ) u_dut (
            .clk_in(clk), .rst_in(rst), .start_in(start),
            .busy_out(busy), .frame_done_out(fdone), .error_out(err),
            .rd_en_out(rd_en), .rd_addr_out(rd_addr), .rd_data_in(rd_data),
            .coll_data_out(cdata), .coll_valid_out(cv),
            .coll_result_in(cres), .coll_done_in(done_in),
            .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data)
        );

        // BRAM with RL-cycle read latency; junk outside the valid slot
        always @(posedge clk) begin
            av[0] <= rd_en;
            ap[0] <= rd_addr;
            for (int i = 1; i < RL; i++) begin
                av[i] <= av[i-1];
                ap[i] <= ap[i-1];
            end
        end
        assign rd_data = av[RL-1] ? bram_word(int'(ap[RL-1])) : {9{8'hEE}};

        // Fixed-latency collision unit, cleared with the controller
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < CLAT; i++) begin
                    cvp[i] <= 1'b0;
                    cdp[i] <= '0;
                end
            end else begin
                cvp[0] <= cv;
                cdp[0] <= cdata;
                for (int i = 1; i < CLAT; i++) begin
                    cvp[i] <= cvp[i-1];
                    cdp[i] <= cdp[i-1];
                end
            end
        end
        assign done_in = cvp[CLAT-1] | spur;
        assign cres    = plus1(cdp[CLAT-1]);
    end

    task automatic chk(input string name, input int k, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // One cycle of the sweep model for instance k: check, then advance
    task automatic step(input int k, input int rl, input int mi,
                        input logic busy, input logic fd, input logic er,
                        input logic re, input logic [3:0] ra,
                        input logic cv, input logic [71:0] cd,
                        input logic we, input logic [3:0] wa, input logic [71:0] wd,
                        input logic dn, input logic st);
        bit was_active, exp_cv, exp_re;
        if (rst) begin
            chk("reset_outputs", k, 72'(|{busy, fd, er, re, ra, cv, cd, we, wa, wd}), 72'(0));
            active[k] = 0; issued[k] = 0; written[k] = 0; cv_n[k] = 0;
            done_n[k] = 0; dwait[k] = 0; wr_pend[k] = 0; err_m[k] = 0;
        end else begin
            was_active = active[k];
            chk("error", k, 72'(er), 72'(err_m[k]));
            chk("busy", k, 72'(busy), 72'(active[k]));
            // i-th read must come back exactly rl+1 cycles after it was issued
            exp_cv = 1'b0;
            if (cv_n[k] < issued[k]) exp_cv = (itime[k][cv_n[k]] + rl + 1 == cyc);
            chk("coll_valid", k, 72'(cv), 72'(exp_cv));
            if (cv && cv_n[k] < issued[k]) begin
                chk("coll_data", k, cd, bram_word(cv_n[k]));
                if (cv_n[k] == 0) chk("coll_data_a0_d0", k, 72'(cd[7:0]), 72'(8'hA5));
                cv_n[k]++;
            end
            // reads: ascending, limited by outstanding (read minus written) cells
            exp_re = active[k] && (issued[k] < N) && ((issued[k] - written[k]) < mi);
            chk("rd_en", k, 72'(re), 72'(exp_re));
            if (re && issued[k] < N) begin
                chk("rd_addr", k, 72'(ra), 72'(issued[k]));
                itime[k][issued[k]] = cyc;
                issued[k]++;
            end
            // writes: one cycle after each result, j-th result goes to address j
            chk("wr_en", k, 72'(we), 72'(wr_pend[k]));
            if (we && wr_pend[k]) begin
                chk("wr_addr", k, 72'(wa), 72'(wr_idx[k]));
                chk("wr_data", k, wd, plus1(bram_word(wr_idx[k])));
                if (wr_idx[k] == N - 1) chk("wr_data_a15_d8", k, 72'(wd[71:64]), 72'(8'h5E));
                written[k]++;
            end
            wr_pend[k] = 1'b0;
            if (dn) begin
                if (done_n[k] < cv_n[k]) begin
                    wr_pend[k] = 1'b1;
                    wr_idx[k]  = done_n[k];
                    done_n[k]++;
                end else begin
                    err_m[k] = 1'b1;
                end
            end
            // completion: one pulse shortly after the 16th write
            if (fd) begin
                chk("frame_done", k, 72'({was_active, 5'(written[k])}), 72'({1'b1, 5'd16}));
                active[k] = 0;
            end else if (active[k] && written[k] == N) begin
                dwait[k]++;
                if (dwait[k] > 4) begin
                    chk("frame_done_timeout", k, 72'(fd), 72'(1));
                    active[k] = 0;
                end
            end
            if (!was_active && st) begin
                active[k] = 1; issued[k] = 0; written[k] = 0;
                cv_n[k] = 0; done_n[k] = 0; dwait[k] = 0;
            end
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        if (to_flag && !to_seen) begin
            to_seen = 1'b1;
            chk("wait_bound", 0, 72'(to_flag), 72'(0));
        end
        step(0, 1, 32, g_inst[0].busy, g_inst[0].fdone, g_inst[0].err, g_inst[0].rd_en,
             g_inst[0].rd_addr, g_inst[0].cv, g_inst[0].cdata, g_inst[0].wr_en,
             g_inst[0].wr_addr, g_inst[0].wr_data, g_inst[0].done_in, start);
        step(1, 2, 4, g_inst[1].busy, g_inst[1].fdone, g_inst[1].err, g_inst[1].rd_en,
             g_inst[1].rd_addr, g_inst[1].cv, g_inst[1].cdata, g_inst[1].wr_en,
             g_inst[1].wr_addr, g_inst[1].wr_data, g_inst[1].done_in, start);
        step(2, 3, 32, g_inst[2].busy, g_inst[2].fdone, g_inst[2].err, g_inst[2].rd_en,
             g_inst[2].rd_addr, g_inst[2].cv, g_inst[2].cdata, g_inst[2].wr_en,
             g_inst[2].wr_addr, g_inst[2].wr_data, g_inst[2].done_in, start);
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        @(posedge clk);
        while ((g_inst[0].busy | g_inst[1].busy | g_inst[2].busy) && n < lim) begin
            @(posedge clk);
            n++;
        end
        if (n >= lim) to_flag = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_issued(input int k, input int v, input int lim);
        int n = 0;
        while (issued[k] < v && n < lim) begin
            @(posedge clk);
            n++;
        end
        if (n >= lim) to_flag = 1'b1;
    endtask

    // Directed stimulus
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // plain sweep on all instances
        pulse_start();
        wait_idle(800);

        // start held through the read phase, then re-pulsed while draining
        @(posedge clk); #1 start = 1'b1;
        wait_issued(0, N, 200);
        #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(800);

        // second sweep from idle starts again at address 0
        pulse_start();
        wait_idle(800);

        // reset at read 7 of the throttled instance, then a clean sweep
        pulse_start();
        wait_issued(1, 7, 200);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        pulse_start();
        wait_idle(800);

        // orphan result while idle
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        repeat (10) @(posedge clk);

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
